// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmitter (and the future receiver).
//   tx_state_t : transmitter FSM states
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS  : payload bits per frame
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

   // Clock cycles in one complete frame for a given bit period.
   function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
      return FRAME_BITS * clks_per_bit;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping read/write pointers and an occupancy counter.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (clears pointers and level)
//   push_i  : enqueue din_i; accepted when not full, or when full and popping
//   pop_i   : dequeue head; ignored when empty
//   din_i   : byte to enqueue
//   dout_o  : current head byte (valid when not empty)
//   level_o : occupancy, 0..DEPTH
//   full_o  : level_o == DEPTH
//   empty_o : level_o == 0
module byte_fifo #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the head slot, so a push into a full
   // FIFO is still accepted then.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; only locations behind valid pointers are read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/byte_uart_tx.sv
// Byte-store consumer: buffers one-cycle core write strobes in a FIFO and
// serialises them as UART 8N1 without ever stalling the core.
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset; aborts any frame, tx_o high
//   write_i    : byte-write strobe (one cycle per byte)
//   value_i    : write data, only [7:0] transmitted
//   tx_o       : serial line, idle high, registered
//   busy_o     : frame in flight or bytes queued
//   overflow_o : sticky, a byte was dropped on a full FIFO
//   level_o    : FIFO occupancy
module byte_uart_tx
   import uart_pkg::*;
#(
   parameter  int unsigned CLKS_PER_BIT = 16,
   parameter  int unsigned FIFO_DEPTH   = 8,
   localparam int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          write_i,
   input  logic [31:0]   value_i,
   output logic          tx_o,
   output logic          busy_o,
   output logic          overflow_o,
   output logic [LW-1:0] level_o
);

   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   tx_state_t     state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          overflow_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [LW-1:0] fifo_level;
   logic          baud_last;
   logic          pop;
   logic          unused_value_hi;

   assign unused_value_hi = ^value_i[31:8];

   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

   // Pop when idle, or at the very last STOP cycle so the next start bit
   // follows the stop bit with no idle gap.
   assign pop = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == STOP) && baud_last));

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (write_i),
      .pop_i   (pop),
      .din_i   (value_i[7:0]),
      .dout_o  (fifo_dout),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // tx_q is driven from the state of the previous cycle, so the start bit
   // appears one edge after the pop and every level lasts CLKS_PER_BIT cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (write_i && fifo_full && !pop) overflow_q <= 1'b1;

         unique case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= fifo_dout;
                  baud_q  <= '0;
                  state_q <= START;
               end
            end

            START: begin
               tx_q <= 1'b0;
               if (baud_last) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            DATA: begin
               tx_q <= shift_q[0];
               if (baud_last) begin
                  baud_q  <= '0;
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'(DATA_BITS - 1)) begin
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            STOP: begin
               tx_q <= 1'b1;
               if (baud_last) begin
                  baud_q <= '0;
                  if (pop) begin
                     shift_q <= fifo_dout;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            default: begin
               tx_q    <= 1'b1;
               baud_q  <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_o       = tx_q;
   assign overflow_o = overflow_q;
   assign level_o    = fifo_level;
   assign busy_o     = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_byte_uart_tx.sv
module tb_byte_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = uart_pkg::FRAME_BITS * CPB;

   logic        clk;
   logic        rst_i;
   logic        write_i;
   logic [31:0] value_i;
   logic        tx_o;
   logic        busy_o;
   logic        overflow_o;
   logic [2:0]  level_o;

   byte_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .write_i    (write_i),
      .value_i    (value_i),
      .tx_o       (tx_o),
      .busy_o     (busy_o),
      .overflow_o (overflow_o),
      .level_o    (level_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: a byte queue plus the schedule of frames.
   // A frame popped at edge p drives the line after edges p+1..p+FRAME;
   // the transmitter can take the next byte at edge F = p+FRAME.
   logic [7:0] q[$];
   int         e;
   int         p;
   int         F;
   logic [7:0] cur;
   logic       ov;
   string      phase;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s/%s obs=%0h exp=%0h at edge %0d", phase, tag, obs, exp, e);
      end
   endtask

   task automatic model_reset();
      q.delete();
      p   = -100000;
      F   = e;
      cur = '0;
      ov  = 1'b0;
   endtask

   task automatic step(input logic w, input logic [31:0] val);
      int   d;
      int   idx;
      logic exp_tx;
      write_i = w;
      value_i = val;
      @(posedge clk);
      e++;
      if (q.size() != 0 && e >= F) begin
         cur = q.pop_front();
         p   = e;
         F   = e + FRAME;
      end
      if (w) begin
         if (q.size() < DEPTH) q.push_back(val[7:0]);
         else                  ov = 1'b1;
      end
      #1;
      write_i = 1'b0;
      value_i = '0;
      d      = e - p;
      exp_tx = 1'b1;
      if (d >= 1 && d <= FRAME) begin
         idx = (d - 1) / CPB;
         if (idx == 0)      exp_tx = 1'b0;
         else if (idx <= 8) exp_tx = cur[idx-1];
      end
      chk("tx", 32'(tx_o), 32'(exp_tx));
      chk("level", 32'(level_o), 32'(q.size()));
      chk("busy", 32'(busy_o), 32'((e < F) || (q.size() != 0)));
      chk("overflow", 32'(overflow_o), 32'(ov));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(q.size() == 0 && e >= F) && n < 2000) begin
         step(1'b0, '0);
         n++;
      end
      chk("drain_timeout", 32'(n < 2000), 32'(1));
      repeat (3) step(1'b0, '0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #1;
      chk("rst_tx", 32'(tx_o), 32'(1));
      chk("rst_level", 32'(level_o), 32'(0));
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_ovf", 32'(overflow_o), 32'(0));
      repeat (2) begin
         @(posedge clk);
         e++;
      end
      model_reset();
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      int n;
      rst_i   = 1'b1;
      write_i = 1'b0;
      value_i = '0;
      e       = 0;
      phase   = "reset";
      model_reset();
      do_reset();

      phase = "single55";
      step(1'b1, 32'h0000_0055);
      step(1'b0, '0);
      chk("tx_pre_start", 32'(tx_o), 32'(1));
      step(1'b0, '0);
      chk("tx_start", 32'(tx_o), 32'(0));
      drain();

      phase = "upper_ignored";
      step(1'b1, 32'hDEAD_BEA5);
      drain();

      phase = "burst3";
      step(1'b1, 32'h01);
      step(1'b1, 32'h02);
      step(1'b1, 32'h03);
      chk("peak_level", 32'(level_o), 32'(2));
      drain();

      phase = "full_pop_push";
      for (int i = 0; i < 5; i++) step(1'b1, 32'(8'h10 + i));
      chk("full_level", 32'(level_o), 32'(4));
      n = 0;
      while (e + 1 != F && n < 200) begin
         step(1'b0, '0);
         n++;
      end
      chk("align_timeout", 32'(n < 200), 32'(1));
      step(1'b1, 32'h3C);
      chk("fp_level", 32'(level_o), 32'(4));
      chk("fp_no_ovf", 32'(overflow_o), 32'(0));
      drain();

      phase = "overflow";
      for (int i = 0; i < 6; i++) step(1'b1, 32'(8'hA0 + i));
      chk("ovf_set", 32'(overflow_o), 32'(1));
      drain();
      chk("ovf_sticky", 32'(overflow_o), 32'(1));

      phase = "reset_mid";
      do_reset();
      step(1'b1, 32'hA3);
      repeat (19) step(1'b0, '0);
      do_reset();
      step(1'b1, 32'hFF);
      drain();

      phase = "random";
      for (int i = 0; i < 900; i++) begin
         step($urandom_range(0, 99) < 12, $urandom);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
